// File: rtl/gpr_file_if.sv
// gpr_file_if: register-file bus between decode and gpr_file.
//   master : drives read/write addresses, immediate controls, link and
//            scoreboard controls; receives operand data and stall.
//   slave  : the register file side (gpr_file).
interface gpr_file_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [15:0]   imm;
    logic          alu_src;
    logic          imm_zext;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          lnk_en;
    logic [DW-1:0] lnk_data;
    logic          pend_set;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] rs_value;
    logic [DW-1:0] rt_raw;
    logic [DW-1:0] rt_value;
    logic          stall;

    modport master (
        output rs_addr, rt_addr, imm, alu_src, imm_zext,
               wr_en, wr_addr, wr_data, lnk_en, lnk_data,
               pend_set, pend_addr,
        input  rs_value, rt_raw, rt_value, stall
    );

    modport slave (
        input  rs_addr, rt_addr, imm, alu_src, imm_zext,
               wr_en, wr_addr, wr_data, lnk_en, lnk_data,
               pend_set, pend_addr,
        output rs_value, rt_raw, rt_value, stall
    );
endinterface

// File: rtl/gpr_file.sv
// gpr_file: parametrised MIPS general-purpose register file.
//   Two combinational read ports (optional write-first bypass), one clocked
//   data write port, a link-register write port for JAL, a per-register
//   load-pending scoreboard driving stall, and the ALUSrc operand-B mux with
//   sign/zero extension of the 16-bit immediate.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - gpr_file_if.slave (addresses, write/link/pend controls, imm,
//           alu_src, imm_zext in; rs_value, rt_raw, rt_value, stall out)
module gpr_file #(
    parameter int unsigned DW       = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned AW       = $clog2(NREG),
    parameter int unsigned LINK_REG = NREG - 1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    gpr_file_if.slave    bus
);
    localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] pending;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] set_vec;

    logic          lnk_do;
    logic          wr_do;
    logic          hit_wr_rs, hit_lnk_rs, hit_wr_rt, hit_lnk_rt;
    logic          clr_rs, clr_rt;
    logic [DW-1:0] rs_d, rt_d, ext_imm;

    // On a wr/lnk collision the link write wins, so the data write is dropped.
    assign lnk_do = bus.lnk_en && (LINK_A != '0);
    assign wr_do  = bus.wr_en && (bus.wr_addr != '0) &&
                    !(bus.lnk_en && (bus.wr_addr == LINK_A));

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            clr_vec[i] = (wr_do  && (bus.wr_addr == AW'(i))) ||
                         (lnk_do && (LINK_A == AW'(i)));
            set_vec[i] = bus.pend_set && (bus.pend_addr == AW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
        end else begin
            if (wr_do) begin
                regs[bus.wr_addr] <= bus.wr_data;
            end
            if (lnk_do) begin
                regs[LINK_A] <= bus.lnk_data;
            end
            // Set is applied after clear so a same-address load issue wins.
            for (int unsigned i = 0; i < NREG; i++) begin
                if (clr_vec[i]) pending[i] <= 1'b0;
                if (set_vec[i]) pending[i] <= 1'b1;
            end
        end
    end

    always_comb begin
        hit_wr_rs  = wr_do  && (bus.wr_addr == bus.rs_addr);
        hit_lnk_rs = lnk_do && (LINK_A == bus.rs_addr);
        hit_wr_rt  = wr_do  && (bus.wr_addr == bus.rt_addr);
        hit_lnk_rt = lnk_do && (LINK_A == bus.rt_addr);
        clr_rs     = BYPASS && (hit_wr_rs || hit_lnk_rs);
        clr_rt     = BYPASS && (hit_wr_rt || hit_lnk_rt);

        rs_d = regs[bus.rs_addr];
        if (bus.rs_addr == '0)       rs_d = '0;
        else if (BYPASS && hit_lnk_rs) rs_d = bus.lnk_data;
        else if (BYPASS && hit_wr_rs)  rs_d = bus.wr_data;

        rt_d = regs[bus.rt_addr];
        if (bus.rt_addr == '0)       rt_d = '0;
        else if (BYPASS && hit_lnk_rt) rt_d = bus.lnk_data;
        else if (BYPASS && hit_wr_rt)  rt_d = bus.wr_data;

        // Casting the signed immediate to DW bits performs the sign fill.
        ext_imm = bus.imm_zext ? DW'(bus.imm) : DW'($signed(bus.imm));
    end

    // Outputs are forced quiet while reset is held so a write presented in
    // the reset cycle cannot leak through the bypass path.
    assign bus.rs_value = rst_n ? rs_d : '0;
    assign bus.rt_raw   = rst_n ? rt_d : '0;
    assign bus.rt_value = bus.alu_src ? ext_imm : bus.rt_raw;
    assign bus.stall    = rst_n &&
        (((bus.rs_addr != '0) && pending[bus.rs_addr] && !clr_rs) ||
         ((bus.rt_addr != '0) && pending[bus.rt_addr] && !clr_rt && !bus.alu_src));
endmodule

// File: tb/tb_gpr_file.sv
module tb_gpr_file;
  logic clk = 1'b0;
  logic rst_n;
  logic done = 1'b0;
  always #5 clk = ~clk;

  gpr_file_if #(.DW(32), .AW(5)) if0 ();
  gpr_file_if #(.DW(32), .AW(5)) if1 ();

  gpr_file #(.DW(32), .NREG(32), .BYPASS(1'b1)) u_byp (.clk(clk), .rst_n(rst_n), .bus(if0));
  gpr_file #(.DW(32), .NREG(32), .BYPASS(1'b0)) u_nob (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if1.rs_addr   = if0.rs_addr;
  assign if1.rt_addr   = if0.rt_addr;
  assign if1.imm       = if0.imm;
  assign if1.alu_src   = if0.alu_src;
  assign if1.imm_zext  = if0.imm_zext;
  assign if1.wr_en     = if0.wr_en;
  assign if1.wr_addr   = if0.wr_addr;
  assign if1.wr_data   = if0.wr_data;
  assign if1.lnk_en    = if0.lnk_en;
  assign if1.lnk_data  = if0.lnk_data;
  assign if1.pend_set  = if0.pend_set;
  assign if1.pend_addr = if0.pend_addr;

  localparam int RS = 0, RTR = 1, RTV = 2, STL = 3;

  typedef struct {
    string       name;
    int          dut;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  function automatic logic [31:0] sample(input int d, input int s);
    logic [31:0] v;
    case (s)
      RS:      v = (d == 0) ? if0.rs_value : if1.rs_value;
      RTR:     v = (d == 0) ? if0.rt_raw   : if1.rt_raw;
      RTV:     v = (d == 0) ? if0.rt_value : if1.rt_value;
      default: v = (d == 0) ? 32'(if0.stall) : 32'(if1.stall);
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = q.pop_front();
      act = sample(e.dut, e.sel);
      total++;
      if (act === e.exp) passed++;
      else $display("FAIL %s dut%0d: got %h expected %h", e.name, e.dut, act, e.exp);
    end
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout: wait for end of stimulus expired");
      $finish;
    end
  end

  task automatic chk_now(input string n, input int d, input int s, input logic [31:0] v);
    logic [31:0] act;
    #1;
    act = sample(d, s);
    total++;
    if (act === v) passed++;
    else $display("FAIL %s dut%0d (direct): got %h expected %h", n, d, act, v);
  endtask

  task automatic exp1(input string n, input int d, input int s, input logic [31:0] v);
    exp_t e;
    e.name = n; e.dut = d; e.sel = s; e.exp = v;
    q.push_back(e);
  endtask

  task automatic exp2(input string n, input int s, input logic [31:0] v);
    exp1(n, 0, s, v);
    exp1(n, 1, s, v);
  endtask

  task automatic idle();
    if0.rs_addr = '0; if0.rt_addr = '0; if0.imm = '0;
    if0.alu_src = 1'b0; if0.imm_zext = 1'b0;
    if0.wr_en = 1'b0; if0.wr_addr = '0; if0.wr_data = '0;
    if0.lnk_en = 1'b0; if0.lnk_data = '0;
    if0.pend_set = 1'b0; if0.pend_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    step();
    if0.rs_addr = 5'd5; if0.rt_addr = 5'd6;
    exp2("rst_hold_rs", RS, 32'h0);
    exp2("rst_hold_stall", STL, 32'h0);
    chk_now("rst_hold_rt_direct", 0, RTV, 32'h0);
    chk_now("rst_hold_stall_direct", 1, STL, 32'h0);
    step();
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 32; i++) begin
      if0.rs_addr = 5'(i);
      if0.rt_addr = 5'(31 - i);
      exp1("rst_read_rs", 0, RS, 32'h0);
      exp1("rst_read_rt", 0, RTR, 32'h0);
      exp1("rst_stall", 0, STL, 32'h0);
      step();
    end

    if0.wr_en = 1'b1; if0.wr_addr = 5'd5; if0.wr_data = 32'hDEADBEEF; if0.rs_addr = 5'd5;
    exp1("bypass_rs", 0, RS, 32'hDEADBEEF);
    exp1("nobypass_rs", 1, RS, 32'h0);
    step();
    if0.rs_addr = 5'd5;
    exp2("write_visible", RS, 32'hDEADBEEF);
    step();

    if0.wr_en = 1'b1; if0.wr_addr = 5'd0; if0.wr_data = 32'h1234; if0.rs_addr = 5'd0;
    exp2("r0_bypass", RS, 32'h0);
    step();
    if0.rs_addr = 5'd0;
    exp2("r0_read", RS, 32'h0);
    step();

    if0.lnk_en = 1'b1; if0.lnk_data = 32'h00400008;
    if0.wr_en = 1'b1; if0.wr_addr = 5'd31; if0.wr_data = 32'h55; if0.rs_addr = 5'd31;
    exp1("lnk_bypass", 0, RS, 32'h00400008);
    exp1("lnk_nobypass", 1, RS, 32'h0);
    step();
    if0.rs_addr = 5'd31;
    exp2("lnk_written", RS, 32'h00400008);
    step();

    if0.wr_en = 1'b1; if0.wr_addr = 5'd6; if0.wr_data = 32'h1111;
    step();
    if0.rt_addr = 5'd6; if0.imm = 16'h8001; if0.alu_src = 1'b1; if0.imm_zext = 1'b0;
    exp2("imm_sext", RTV, 32'hFFFF8001);
    exp2("imm_rt_raw", RTR, 32'h1111);
    step();
    if0.rt_addr = 5'd6; if0.imm = 16'h8001; if0.alu_src = 1'b1; if0.imm_zext = 1'b1;
    exp2("imm_zext", RTV, 32'h00008001);
    step();
    if0.rt_addr = 5'd6; if0.imm = 16'h8001; if0.alu_src = 1'b0;
    exp2("alu_src0", RTV, 32'h1111);
    step();

    if0.pend_set = 1'b1; if0.pend_addr = 5'd7; if0.rs_addr = 5'd7;
    exp2("pend_not_yet", STL, 32'h0);
    step();
    if0.rs_addr = 5'd7;
    exp2("pend_stall", STL, 32'h1);
    step();
    if0.wr_en = 1'b1; if0.wr_addr = 5'd7; if0.wr_data = 32'h42; if0.rs_addr = 5'd7;
    exp1("clr_stall_byp", 0, STL, 32'h0);
    exp1("clr_rs_byp", 0, RS, 32'h42);
    exp1("clr_stall_nob", 1, STL, 32'h1);
    exp1("clr_rs_nob", 1, RS, 32'h0);
    step();
    if0.rs_addr = 5'd7;
    exp2("after_clr_stall", STL, 32'h0);
    exp2("after_clr_rs", RS, 32'h42);
    step();

    if0.pend_set = 1'b1; if0.pend_addr = 5'd9;
    if0.wr_en = 1'b1; if0.wr_addr = 5'd9; if0.wr_data = 32'h99;
    step();
    if0.rs_addr = 5'd9;
    exp2("set_wins_stall", STL, 32'h1);
    exp2("set_wins_data", RS, 32'h99);
    step();
    if0.rt_addr = 5'd9; if0.alu_src = 1'b1;
    exp2("rt_imm_nostall", STL, 32'h0);
    step();
    if0.rt_addr = 5'd9; if0.alu_src = 1'b0;
    exp2("rt_stall", STL, 32'h1);
    step();
    if0.wr_en = 1'b1; if0.wr_addr = 5'd9; if0.wr_data = 32'h99;
    step();

    if0.pend_set = 1'b1; if0.pend_addr = 5'd31;
    step();
    if0.lnk_en = 1'b1; if0.lnk_data = 32'hABC; if0.rs_addr = 5'd31;
    exp1("lnk_clr_stall_byp", 0, STL, 32'h0);
    exp1("lnk_clr_rs_byp", 0, RS, 32'hABC);
    exp1("lnk_clr_stall_nob", 1, STL, 32'h1);
    exp1("lnk_clr_rs_nob", 1, RS, 32'h00400008);
    step();
    if0.rs_addr = 5'd31;
    exp2("lnk_after_stall", STL, 32'h0);
    exp2("lnk_after_rs", RS, 32'hABC);
    step();

    rst_n = 1'b0;
    if0.pend_set = 1'b1; if0.pend_addr = 5'd3;
    if0.wr_en = 1'b1; if0.wr_addr = 5'd4; if0.wr_data = 32'h77;
    if0.rs_addr = 5'd4; if0.rt_addr = 5'd7;
    exp2("midrst_rs", RS, 32'h0);
    exp2("midrst_rt", RTR, 32'h0);
    exp2("midrst_stall", STL, 32'h0);
    step();
    rst_n = 1'b1;
    if0.rs_addr = 5'd3; if0.rt_addr = 5'd4;
    exp2("postrst_stall", STL, 32'h0);
    exp2("postrst_r4", RTR, 32'h0);
    chk_now("postrst_stall_direct", 0, STL, 32'h0);
    chk_now("postrst_r4_direct", 0, RTR, 32'h0);
    step();
    if0.rs_addr = 5'd5; if0.rt_addr = 5'd31;
    exp2("postrst_r5", RS, 32'h0);
    exp2("postrst_r31", RTR, 32'h0);
    step();

    @(negedge clk);
    #1;
    done = 1'b1;
    if (q.size() != 0 || total < 12)
      $display("FAIL end: %0d expectations unchecked, %0d checks run", q.size(), total);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
